// File: rtl/counter_arbiter.sv
// Round-robin scheduler that lends a shared 3-bit binary/Gray up-counter
// to one of two requesters for a burst of 0..15 counting steps.
module counter_arbiter (
    input  logic       clk_i,
    input  logic       reset_i,
    input  logic [1:0] req_i,
    input  logic [1:0] req_mode_i,
    input  logic [1:0] req_clr_i,
    input  logic [3:0] req_len0_i,
    input  logic [3:0] req_len1_i,
    input  logic       abort_i,
    output logic [1:0] gnt_o,
    output logic [1:0] done_o,
    output logic       busy_o,
    output logic       owner_o,
    output logic [2:0] count_o,
    output logic       mode_o
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_e;

    state_e     state_q, state_d;
    logic [2:0] count_q, count_d;
    logic       mode_q, mode_d;
    logic       owner_q, owner_d;
    logic       last_q, last_d;
    logic [3:0] remaining_q, remaining_d;
    logic [1:0] gnt_q, gnt_d;
    logic [1:0] done_q, done_d;
    logic       busy_q, busy_d;
    logic       winner;
    logic       grantNow;

    // Gray successor walks the reflected code 000,001,011,010,110,111,101,100.
    function automatic logic [2:0] grayNext(input logic [2:0] c);
        logic [2:0] n;
        case (c)
            3'b000:  n = 3'b001;
            3'b001:  n = 3'b011;
            3'b011:  n = 3'b010;
            3'b010:  n = 3'b110;
            3'b110:  n = 3'b111;
            3'b111:  n = 3'b101;
            3'b101:  n = 3'b100;
            default: n = 3'b000;
        endcase
        return n;
    endfunction

    function automatic logic [2:0] countNext(input logic [2:0] c, input logic m);
        return m ? grayNext(c) : c + 3'd1;
    endfunction

    // With both requesting, the one not served last wins; otherwise the sole requester.
    always_comb begin
        winner   = (req_i == 2'b11) ? ~last_q : req_i[1];
        grantNow = (state_q == IDLE) && (|req_i);
    end

    always_comb begin
        state_d     = state_q;
        count_d     = count_q;
        mode_d      = mode_q;
        owner_d     = owner_q;
        last_d      = last_q;
        remaining_d = remaining_q;

        case (state_q)
            IDLE: begin
                if (grantNow) begin
                    state_d     = RUN;
                    owner_d     = winner;
                    last_d      = winner;
                    mode_d      = req_mode_i[winner];
                    remaining_d = winner ? req_len1_i : req_len0_i;
                    if (req_clr_i[winner]) begin
                        count_d = 3'b000;
                    end
                end
            end
            RUN: begin
                if (abort_i || (remaining_q == 4'd0)) begin
                    state_d = DONE;
                end else begin
                    count_d     = countNext(count_q, mode_q);
                    remaining_d = remaining_q - 4'd1;
                    if (remaining_q == 4'd1) begin
                        state_d = DONE;
                    end
                end
            end
            DONE: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase

        // Pulses are computed from next state so they line up with the state they describe.
        gnt_d  = grantNow ? (2'b01 << winner) : 2'b00;
        done_d = (state_d == DONE) ? (2'b01 << owner_d) : 2'b00;
        busy_d = (state_d != IDLE);
    end

    always_ff @(posedge clk_i or posedge reset_i) begin
        if (reset_i) begin
            state_q     <= IDLE;
            count_q     <= 3'b000;
            mode_q      <= 1'b0;
            owner_q     <= 1'b0;
            last_q      <= 1'b1;
            remaining_q <= 4'd0;
            gnt_q       <= 2'b00;
            done_q      <= 2'b00;
            busy_q      <= 1'b0;
        end else begin
            state_q     <= state_d;
            count_q     <= count_d;
            mode_q      <= mode_d;
            owner_q     <= owner_d;
            last_q      <= last_d;
            remaining_q <= remaining_d;
            gnt_q       <= gnt_d;
            done_q      <= done_d;
            busy_q      <= busy_d;
        end
    end

    assign gnt_o   = gnt_q;
    assign done_o  = done_q;
    assign busy_o  = busy_q;
    assign owner_o = owner_q;
    assign count_o = count_q;
    assign mode_o  = mode_q;

endmodule

// File: tb/tb_counter_arbiter.sv
// Directed bench for counter_arbiter: hand-computed vectors checked with
// immediate assertions one cycle at a time.
module tb_counter_arbiter;

    logic       clk;
    logic       reset;
    logic [1:0] req;
    logic [1:0] reqMode;
    logic [1:0] reqClr;
    logic [3:0] reqLen0;
    logic [3:0] reqLen1;
    logic       abort;
    logic [1:0] gnt;
    logic [1:0] done;
    logic       busy;
    logic       owner;
    logic [2:0] count;
    logic       mode;

    int passCount  = 0;
    int checkCount = 0;

    counter_arbiter dut (
        .clk_i      (clk),
        .reset_i    (reset),
        .req_i      (req),
        .req_mode_i (reqMode),
        .req_clr_i  (reqClr),
        .req_len0_i (reqLen0),
        .req_len1_i (reqLen1),
        .abort_i    (abort),
        .gnt_o      (gnt),
        .done_o     (done),
        .busy_o     (busy),
        .owner_o    (owner),
        .count_o    (count),
        .mode_o     (mode)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Advance one edge and settle so outputs are sampled away from the edge.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic applyStimulus(input logic [1:0] r, input logic [1:0] m,
                                 input logic [1:0] c, input logic [3:0] l0,
                                 input logic [3:0] l1, input logic a);
        req     = r;
        reqMode = m;
        reqClr  = c;
        reqLen0 = l0;
        reqLen1 = l1;
        abort   = a;
    endtask

    task automatic checkOutput(input string tag, input logic [7:0] observed,
                               input logic [7:0] expected);
        checkCount++;
        assert (observed === expected) passCount++;
        else $error("[TB] FAIL %s observed=%0h expected=%0h", tag, observed, expected);
    endtask

    task automatic checkAll(input string tag, input logic [1:0] g, input logic [1:0] d,
                            input logic b, input logic o, input logic [2:0] c);
        checkOutput({tag, ".gnt"},   {6'b0, gnt},   {6'b0, g});
        checkOutput({tag, ".done"},  {6'b0, done},  {6'b0, d});
        checkOutput({tag, ".busy"},  {7'b0, busy},  {7'b0, b});
        checkOutput({tag, ".owner"}, {7'b0, owner}, {7'b0, o});
        checkOutput({tag, ".count"}, {5'b0, count}, {5'b0, c});
    endtask

    logic [2:0] graySeq [8];
    logic [1:0] gntSeq  [9];

    initial begin
        graySeq = '{3'b001, 3'b011, 3'b010, 3'b110, 3'b111, 3'b101, 3'b100, 3'b000};
        gntSeq  = '{2'b01, 2'b00, 2'b00, 2'b00, 2'b10, 2'b00, 2'b00, 2'b00, 2'b01};

        reset = 1'b1;
        applyStimulus(2'b00, 2'b00, 2'b00, 4'd0, 4'd0, 1'b0);
        #2;
        checkAll("reset", 2'b00, 2'b00, 1'b0, 1'b0, 3'b000);
        checkOutput("reset.mode", {7'b0, mode}, 8'h00);
        tick();
        reset = 1'b0;

        // Requester 0, binary, len 5, clear
        applyStimulus(2'b01, 2'b00, 2'b01, 4'd5, 4'd0, 1'b0);
        tick();
        checkAll("b5.grant", 2'b01, 2'b00, 1'b1, 1'b0, 3'b000);
        applyStimulus(2'b00, 2'b00, 2'b00, 4'd5, 4'd0, 1'b0);
        for (int i = 1; i <= 4; i++) begin
            tick();
            checkAll("b5.step", 2'b00, 2'b00, 1'b1, 1'b0, 3'(i));
        end
        tick();
        checkAll("b5.done", 2'b00, 2'b01, 1'b1, 1'b0, 3'b101);
        tick();
        checkAll("b5.idle", 2'b00, 2'b00, 1'b0, 1'b0, 3'b101);

        // Requester 1, Gray, len 8, clear
        applyStimulus(2'b10, 2'b10, 2'b10, 4'd0, 4'd8, 1'b0);
        tick();
        checkAll("g8.grant", 2'b10, 2'b00, 1'b1, 1'b1, 3'b000);
        checkOutput("g8.mode", {7'b0, mode}, 8'h01);
        applyStimulus(2'b00, 2'b00, 2'b00, 4'd0, 4'd8, 1'b0);
        for (int i = 0; i < 7; i++) begin
            tick();
            checkAll("g8.step", 2'b00, 2'b00, 1'b1, 1'b1, graySeq[i]);
        end
        tick();
        checkAll("g8.done", 2'b00, 2'b10, 1'b1, 1'b1, graySeq[7]);
        tick();
        checkAll("g8.idle", 2'b00, 2'b00, 1'b0, 1'b1, 3'b000);

        // Both requesting continuously, len 2 each, binary, no clear
        applyStimulus(2'b11, 2'b00, 2'b00, 4'd2, 4'd2, 1'b0);
        for (int i = 0; i < 9; i++) begin
            tick();
            checkOutput("rr.gnt", {6'b0, gnt}, {6'b0, gntSeq[i]});
            if (i >= 4 && i < 8) checkOutput("rr.owner1", {7'b0, owner}, 8'h01);
        end
        checkOutput("rr.owner0", {7'b0, owner}, 8'h00);
        applyStimulus(2'b00, 2'b00, 2'b00, 4'd2, 4'd2, 1'b0);
        tick();
        checkAll("rr.step", 2'b00, 2'b00, 1'b1, 1'b0, 3'b101);
        tick();
        checkAll("rr.done", 2'b00, 2'b01, 1'b1, 1'b0, 3'b110);
        tick();
        checkAll("rr.idle", 2'b00, 2'b00, 1'b0, 1'b0, 3'b110);

        // Continue from held 110 with binary wrap, len 3
        applyStimulus(2'b01, 2'b00, 2'b00, 4'd3, 4'd0, 1'b0);
        tick();
        checkAll("wrap.grant", 2'b01, 2'b00, 1'b1, 1'b0, 3'b110);
        applyStimulus(2'b00, 2'b00, 2'b00, 4'd3, 4'd0, 1'b0);
        tick();
        checkAll("wrap.s1", 2'b00, 2'b00, 1'b1, 1'b0, 3'b111);
        tick();
        checkAll("wrap.s2", 2'b00, 2'b00, 1'b1, 1'b0, 3'b000);
        tick();
        checkAll("wrap.done", 2'b00, 2'b01, 1'b1, 1'b0, 3'b001);
        tick();
        checkAll("wrap.idle", 2'b00, 2'b00, 1'b0, 1'b0, 3'b001);

        // Zero-length burst
        applyStimulus(2'b01, 2'b00, 2'b00, 4'd0, 4'd0, 1'b0);
        tick();
        checkAll("len0.grant", 2'b01, 2'b00, 1'b1, 1'b0, 3'b001);
        applyStimulus(2'b00, 2'b00, 2'b00, 4'd0, 4'd0, 1'b0);
        tick();
        checkAll("len0.done", 2'b00, 2'b01, 1'b1, 1'b0, 3'b001);
        tick();
        checkAll("len0.idle", 2'b00, 2'b00, 1'b0, 1'b0, 3'b001);

        // Gray len 10 aborted at the third RUN edge
        applyStimulus(2'b01, 2'b01, 2'b01, 4'd10, 4'd0, 1'b0);
        tick();
        checkAll("abt.grant", 2'b01, 2'b00, 1'b1, 1'b0, 3'b000);
        applyStimulus(2'b00, 2'b01, 2'b00, 4'd10, 4'd0, 1'b0);
        tick();
        checkAll("abt.s1", 2'b00, 2'b00, 1'b1, 1'b0, 3'b001);
        tick();
        checkAll("abt.s2", 2'b00, 2'b00, 1'b1, 1'b0, 3'b011);
        abort = 1'b1;
        tick();
        checkAll("abt.done", 2'b00, 2'b01, 1'b1, 1'b0, 3'b011);
        abort = 1'b0;
        tick();
        checkAll("abt.idle", 2'b00, 2'b00, 1'b0, 1'b0, 3'b011);

        // Binary len 9 killed by asynchronous reset after four steps
        applyStimulus(2'b01, 2'b00, 2'b01, 4'd9, 4'd0, 1'b0);
        tick();
        checkAll("rst.grant", 2'b01, 2'b00, 1'b1, 1'b0, 3'b000);
        applyStimulus(2'b00, 2'b00, 2'b00, 4'd9, 4'd0, 1'b0);
        for (int i = 1; i <= 4; i++) tick();
        checkAll("rst.pre", 2'b00, 2'b00, 1'b1, 1'b0, 3'b100);
        #2;
        reset = 1'b1;
        #1;
        checkAll("rst.async", 2'b00, 2'b00, 1'b0, 1'b0, 3'b000);
        tick();
        tick();
        checkAll("rst.hold", 2'b00, 2'b00, 1'b0, 1'b0, 3'b000);
        reset = 1'b0;

        // After reset, requester 0 wins a simultaneous request
        applyStimulus(2'b11, 2'b00, 2'b00, 4'd1, 4'd1, 1'b0);
        tick();
        checkAll("post.grant", 2'b01, 2'b00, 1'b1, 1'b0, 3'b000);
        applyStimulus(2'b00, 2'b00, 2'b00, 4'd1, 4'd1, 1'b0);
        tick();
        checkAll("post.done", 2'b00, 2'b01, 1'b1, 1'b0, 3'b001);
        tick();
        checkAll("post.idle", 2'b00, 2'b00, 1'b0, 1'b0, 3'b001);

        $display("%0d/%0d checks passed", passCount, checkCount);
        $finish;
    end

endmodule
